// File: rtl/sync_counter_ctrl_if.sv
// sync_counter_ctrl_if
//   Command channel between a bus-side requester and sync_counter_ctrl.
//   Ports (signals):
//     req_valid  - command present (requester -> controller)
//     req_ready  - controller can accept a command (controller -> requester)
//     req_load   - preload counter before counting
//     req_value  - preload value, WIDTH bits
//     req_up     - 1 = count up, 0 = count down
//     req_steps  - number of enable cycles, WIDTH bits, 0 is legal
//   Modports: master (requester side), slave (controller side).
interface sync_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_load;
  logic [WIDTH-1:0] req_value;
  logic             req_up;
  logic [WIDTH-1:0] req_steps;

  modport master (
    output req_valid,
    output req_load,
    output req_value,
    output req_up,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_load,
    input  req_value,
    input  req_up,
    input  req_steps,
    output req_ready
  );
endinterface

// File: rtl/sync_counter_ctrl.sv
// sync_counter_ctrl
//   Command-driven sequencer for a WIDTH-bit synchronous counter datapath.
//   Accepts {load, value, up, steps} over a valid/ready channel, optionally
//   preloads the counter for one cycle, then enables it for exactly 'steps'
//   cycles and reports completion, abort and rollover.
//   Ports:
//     clk, rst   - rising-edge clock, asynchronous active-high reset
//     req        - command channel (slave side), req_ready high only in IDLE
//     abort      - stop an active run (honoured only in RUN)
//     cnt_q      - registered counter value from the datapath
//     cnt_ld     - counter load strobe, cnt_d = load data
//     cnt_en     - counter enable (gated combinationally by abort)
//     cnt_up     - counter direction (1 in IDLE)
//     busy       - high in any state other than IDLE
//     done       - one-cycle completion pulse, aborted qualifies it
//     wrap       - one-cycle pulse the cycle after an enabled rollover
module sync_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  sync_counter_ctrl_if.slave req,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_ld,
  output logic [WIDTH-1:0] cnt_d,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] steps_r;
  logic [WIDTH-1:0] steps_s;
  logic [WIDTH-1:0] value_r;
  logic             up_r;
  logic             abort_r;
  logic             abort_s;
  logic             wrap_r;
  logic             accept_s;
  logic             cnt_en_s;

  // True when an enabled count from q in the given direction rolls over.
  function automatic logic is_rollover(input logic up, input logic [WIDTH-1:0] q);
    if (up) begin
      is_rollover = (q == ALL_ONES);
    end else begin
      is_rollover = (q == ZERO);
    end
  endfunction

  assign accept_s = req.req_valid && (state_r == ST_IDLE);

  // Abort removes the enable in the very cycle it is seen, so an aborted
  // run issues no count in the abort cycle.
  assign cnt_en_s = (state_r == ST_RUN) && !abort;

  assign req.req_ready = (state_r == ST_IDLE);
  assign busy          = (state_r != ST_IDLE);
  assign cnt_ld        = (state_r == ST_LOAD);
  assign cnt_d         = (state_r == ST_LOAD) ? value_r : ZERO;
  assign cnt_en        = cnt_en_s;
  assign cnt_up        = (state_r == ST_IDLE) ? 1'b1 : up_r;
  assign done          = (state_r == ST_DONE);
  assign aborted       = (state_r == ST_DONE) && abort_r;
  assign wrap          = wrap_r;

  // State, step counter and abort flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      steps_r <= ZERO;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_s;
      steps_r <= steps_s;
      abort_r <= abort_s;
    end
  end

  // Next-state logic; the step register counts down remaining enables.
  always_comb begin
    state_s = state_r;
    steps_s = steps_r;
    abort_s = abort_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          steps_s = req.req_steps;
          abort_s = 1'b0;
          if (req.req_load) begin
            state_s = ST_LOAD;
          end else if (req.req_steps != ZERO) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (steps_r != ZERO) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          abort_s = 1'b1;
          state_s = ST_DONE;
        end else begin
          steps_s = steps_r - ONE;
          // Leaving on the cycle the register holds 1 gives exactly
          // 'steps' enable cycles.
          if (steps_r == ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Capture preload value and direction of an accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= ZERO;
      up_r    <= 1'b1;
    end else if (accept_s) begin
      value_r <= req.req_value;
      up_r    <= req.req_up;
    end else begin
      value_r <= value_r;
      up_r    <= up_r;
    end
  end

  // Rollover detect: registered, so it pulses the cycle after the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= cnt_en_s && is_rollover(up_r, cnt_q);
    end
  end

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// tb_sync_counter_ctrl
//   Self-checking bench for sync_counter_ctrl with a behavioural counter
//   datapath. Commands come from a vector table; each command's expected
//   outcome is queued when driven and checked when its done pulse appears.
module tb_sync_counter_ctrl;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_en;
  logic             cnt_up;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             wrap;

  sync_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sync_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .abort   (abort),
    .cnt_q   (cnt_q),
    .cnt_ld  (cnt_ld),
    .cnt_d   (cnt_d),
    .cnt_en  (cnt_en),
    .cnt_up  (cnt_up),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Behavioural counter datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'h0;
    else if (cnt_ld) cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'h1 : cnt_q - 4'h1;
  end

  typedef struct {
    bit         load;
    logic [3:0] value;
    bit         up;
    logic [3:0] steps;
    int         abort_at;   // cycle after accept to raise abort, 0 = never
    int         exp_cyc;    // cycle of done pulse, accept edge = cycle 0
    int         exp_en;
    int         exp_wraps;
    bit         exp_ab;
    logic [3:0] exp_q;      // counter value in the done cycle
    int         exp_gap;    // cycles since previous accept, -1 = don't care
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t vecs[9];
  vec_t e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_cnt_ld"},    32'(cnt_ld),        32'd0);
    chk({tag, "_cnt_en"},    32'(cnt_en),        32'd0);
    chk({tag, "_cnt_up"},    32'(cnt_up),        32'd1);
    chk({tag, "_cnt_d"},     32'(cnt_d),         32'd0);
    chk({tag, "_done"},      32'(done),          32'd0);
    chk({tag, "_aborted"},   32'(aborted),       32'd0);
    chk({tag, "_wrap"},      32'(wrap),          32'd0);
  endtask

  // Monitor: tallies each command's activity and checks it on done.
  int gcyc = 0, acc_cyc = -100, gap = 0, cyc = 0, en_n = 0, ld_n = 0, wr_n = 0, bad = 0;
  bit in_cmd = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      gcyc++;
      if (rst) begin
        in_cmd = 1'b0;
      end else begin
        if (in_cmd) begin
          cyc++;
          if (cnt_en) en_n++;
          if (cnt_ld) ld_n++;
          if (wrap) wr_n++;
          if (sb.size() > 0) begin
            if (cnt_en && cnt_ld) bad++;
            if (cnt_en && (cnt_up != sb[0].up)) bad++;
            if (cnt_ld && (cnt_d != sb[0].value)) bad++;
          end
          if (done) begin
            in_cmd = 1'b0;
            if (sb.size() == 0) begin
              chk("unexpected_done", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("done_cycle", 32'(cyc),     32'(e.exp_cyc));
              chk("enables",    32'(en_n),    32'(e.exp_en));
              chk("loads",      32'(ld_n),    32'(e.load));
              chk("wraps",      32'(wr_n),    32'(e.exp_wraps));
              chk("aborted",    32'(aborted), 32'(e.exp_ab));
              chk("cnt_q",      32'(cnt_q),   32'(e.exp_q));
              chk("ctrl_bad",   32'(bad),     32'd0);
              if (e.exp_gap >= 0) chk("accept_gap", 32'(gap), 32'(e.exp_gap));
            end
          end
        end
        if (bus.req_valid && bus.req_ready) begin
          in_cmd  = 1'b1;
          cyc     = 0;
          en_n    = 0;
          ld_n    = 0;
          wr_n    = 0;
          bad     = 0;
          gap     = gcyc - acc_cyc;
          acc_cyc = gcyc;
        end
      end
    end
  end

  // Drive one command; entered and left at posedge+1.
  task automatic send(input vec_t v, input bit push);
    int t;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      bus.req_valid = 1'b1;
      bus.req_load  = v.load;
      bus.req_value = v.value;
      bus.req_up    = v.up;
      bus.req_steps = v.steps;
      if (push) sb.push_back(v);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (v.abort_at > 0) begin
        repeat (v.abort_at - 1) begin
          @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
      end
    end
  endtask

  vec_t r_cmd, a_cmd, b_cmd;
  int   t, dn;

  initial begin
    //            load  value up    steps abt cyc en wr ab    q     gap
    vecs[0] = '{1'b1, 4'h3, 1'b1, 4'd5,  0, 7,  5, 0, 1'b0, 4'h8, -1}; // load + up
    vecs[1] = '{1'b1, 4'h1, 1'b0, 4'd3,  0, 5,  3, 1, 1'b0, 4'hE, -1}; // down wrap
    vecs[2] = '{1'b0, 4'h7, 1'b1, 4'd0,  0, 1,  0, 0, 1'b0, 4'hE, -1}; // zero steps
    vecs[3] = '{1'b0, 4'h0, 1'b1, 4'd3,  0, 4,  3, 1, 1'b0, 4'h1,  2}; // back-to-back, up wrap
    vecs[4] = '{1'b0, 4'h0, 1'b1, 4'd10, 4, 5,  3, 0, 1'b1, 4'h4, -1}; // abort 4th RUN
    vecs[5] = '{1'b1, 4'hF, 1'b1, 4'd2,  0, 4,  2, 1, 1'b0, 4'h1, -1}; // load F, wrap
    vecs[6] = '{1'b1, 4'h0, 1'b0, 4'd0,  0, 2,  0, 0, 1'b0, 4'h0, -1}; // load, zero steps
    vecs[7] = '{1'b1, 4'h5, 1'b0, 4'd2,  1, 4,  2, 0, 1'b0, 4'h3, -1}; // abort in LOAD ignored
    vecs[8] = '{1'b0, 4'h0, 1'b0, 4'd2,  2, 3,  1, 0, 1'b1, 4'h2, -1}; // abort last RUN

    rst           = 1'b1;
    abort         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_value = 4'h0;
    bus.req_up    = 1'b0;
    bus.req_steps = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) send(vecs[i], 1'b1);

    // Reset mid-RUN: no done, outputs at reset values at once.
    r_cmd = '{1'b0, 4'h0, 1'b1, 4'd9, 0, 0, 0, 0, 1'b0, 4'h0, -1};
    send(r_cmd, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_rst", 32'(dn), 32'd0);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Busy hold: second command waits, first command's fields unaffected.
    a_cmd = '{1'b1, 4'h2, 1'b1, 4'd4, 0, 6, 4, 0, 1'b0, 4'h6, -1};
    b_cmd = '{1'b1, 4'h9, 1'b0, 4'd1, 0, 3, 1, 0, 1'b0, 4'h8,  7};
    send(a_cmd, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_load  = b_cmd.load;
    bus.req_value = b_cmd.value;
    bus.req_up    = b_cmd.up;
    bus.req_steps = b_cmd.steps;
    sb.push_back(b_cmd);
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("hold_ready_seen", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
